// File: rtl/dif_lut_pkg.sv
// rtl/dif_lut_pkg.sv - shared widths, key floor constant and fold/saturate helper
package dif_lut_pkg;

   // Default input word width and LUT key width for the K10W12 family.
   localparam int WORD_BIT  = 16;
   localparam int DEF_KEY_W = 10;

   // Lowest key the symmetric LUT comparator accepts.
   localparam int KEY_MIN   = -(2 ** (DEF_KEY_W - 1));

   typedef struct packed {
      logic signed [31:0] key;
      logic               mirror;
      logic               sat;
   } fold_sat_t;

   // Integer-domain fold onto the non-positive axis, floor shift, clamp at the key floor.
   function automatic fold_sat_t fold_sat(input int sample, input int shift, input int key_w);
      fold_sat_t r;
      int        fold;
      int        sh;
      int        kmin;
      r.mirror = (sample > 0);
      fold     = r.mirror ? -sample : sample;
      sh       = fold >>> shift;
      kmin     = -(2 ** (key_w - 1));
      r.sat    = (sh < kmin);
      r.key    = r.sat ? kmin : sh;
      return r;
   endfunction

endpackage

// File: rtl/dif_lut_pipe_reg.sv
// rtl/dif_lut_pipe_reg.sv - single valid/ready register slice with parameterised payload
module dif_lut_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // The slice can take a new word when empty or when its current word leaves this cycle.
   assign ready_o = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // Next state: load on upstream handshake, drain on downstream handshake, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   // State register with synchronous reset that empties the slice.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/dif_lut_key_gen.sv
// rtl/dif_lut_key_gen.sv - folds signed samples into saturated LUT keys with mirror sideband
module dif_lut_key_gen
   import dif_lut_pkg::*;
#(
   parameter int IN_W  = WORD_BIT,
   parameter int KEY_W = DEF_KEY_W,
   parameter int SHIFT = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [KEY_W-1:0] out_key,
   output logic                    out_mirror,
   output logic                    out_sat,
   output logic [CNT_W-1:0]        sat_cnt,
   input  logic                    sat_clr
);

   // Stage 1 carries {mirror, fold}; stage 2 carries {mirror, sat, key}.
   localparam int S1_W      = IN_W + 2;
   localparam int S2_W      = KEY_W + 2;
   localparam int FLOOR_INT = -(2 ** (KEY_W - 1));
   localparam logic signed [IN_W:0]  SH_FLOOR  = (IN_W + 1)'(FLOOR_INT);
   localparam logic        [KEY_W-1:0] KEY_FLOOR = KEY_W'(FLOOR_INT);

   logic signed [IN_W:0]  in_ext;
   logic signed [IN_W:0]  fold_d;
   logic                  mirror_d;

   logic                  s1_valid;
   logic                  s2_ready;
   logic [S1_W-1:0]       s1_data;
   logic                  s1_mirror;
   logic signed [IN_W:0]  s1_fold;
   logic signed [IN_W:0]  sh;
   logic                  sat_d;
   logic [KEY_W-1:0]      key_d;
   logic [S2_W-1:0]       s2_data;

   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // Fold at one extra bit so the most negative sample passes through unchanged.
   always_comb begin
      in_ext   = {in_data[IN_W-1], in_data};
      mirror_d = !in_data[IN_W-1] && (in_data != '0);
      fold_d   = mirror_d ? -in_ext : in_ext;
   end

   dif_lut_pipe_reg #(.W(S1_W)) u_stage1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (in_valid),
      .ready_o (in_ready),
      .data_i  ({mirror_d, fold_d}),
      .valid_o (s1_valid),
      .ready_i (s2_ready),
      .data_o  (s1_data)
   );

   // Floor-shift the folded value and clamp anything below the LUT key floor.
   always_comb begin
      s1_mirror = s1_data[S1_W-1];
      s1_fold   = s1_data[IN_W:0];
      sh        = s1_fold >>> SHIFT;
      sat_d     = (sh < SH_FLOOR);
      key_d     = sat_d ? KEY_FLOOR : sh[KEY_W-1:0];
   end

   dif_lut_pipe_reg #(.W(S2_W)) u_stage2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (s1_valid),
      .ready_o (s2_ready),
      .data_i  ({s1_mirror, sat_d, key_d}),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .data_o  (s2_data)
   );

   assign out_mirror = s2_data[KEY_W+1];
   assign out_sat    = s2_data[KEY_W];
   assign out_key    = s2_data[KEY_W-1:0];
   assign sat_cnt    = cnt_q;

   // Count clamped keys taken downstream; sticks at all-ones, and clear has priority.
   always_comb begin
      cnt_d = cnt_q;
      if (sat_clr) begin
         cnt_d = '0;
      end else if (out_valid && out_ready && out_sat && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Saturation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dif_lut_key_gen.sv
// tb/tb_dif_lut_key_gen.sv - self-checking bench for dif_lut_key_gen
module tb_dif_lut_key_gen;

   localparam int IN_W    = 16;
   localparam int KEY_W   = 10;
   localparam int SHIFT   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int KMIN    = -512;

   logic                    clk;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [IN_W-1:0]         in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [KEY_W-1:0] out_key;
   logic                    out_mirror;
   logic                    out_sat;
   logic [CNT_W-1:0]        sat_cnt;
   logic                    sat_clr;

   int tests = 0;
   int fails = 0;

   typedef struct { int key; bit mirror; bit sat; } exp_t;
   typedef struct { int data; int key; bit mirror; bit sat; } vec_t;

   exp_t q[$];
   int   cnt_m;
   bit   hold_v;
   exp_t hold_e;

   dif_lut_key_gen #(.IN_W(IN_W), .KEY_W(KEY_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_key    (out_key),
      .out_mirror (out_mirror),
      .out_sat    (out_sat),
      .sat_cnt    (sat_cnt),
      .sat_clr    (sat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: fold to <= 0, floor-divide by 2^SHIFT, clamp at the key floor.
   function automatic exp_t model(input int d);
      exp_t e;
      int   f;
      int   div;
      int   sh;
      div      = 1 << SHIFT;
      e.mirror = (d > 0);
      f        = e.mirror ? -d : d;
      sh       = -(((-f) + div - 1) / div);
      e.sat    = (sh < KMIN);
      e.key    = e.sat ? KMIN : sh;
      return e;
   endfunction

   // Scoreboard: ordered expectations, counter model and hold-stability check.
   always @(negedge clk) begin
      exp_t e;
      bit   popped;
      if (rst) begin
         q.delete();
         cnt_m  = 0;
         hold_v = 0;
      end else begin
         popped = 0;
         if (hold_v) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_key", int'(out_key), hold_e.key);
            check("hold_mirror", int'(out_mirror), int'(hold_e.mirror));
            check("hold_sat", int'(out_sat), int'(hold_e.sat));
         end
         check("sat_cnt_model", int'(sat_cnt), cnt_m);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e      = q.pop_front();
               popped = 1;
               check("sb_key", int'(out_key), e.key);
               check("sb_mirror", int'(out_mirror), int'(e.mirror));
               check("sb_sat", int'(out_sat), int'(e.sat));
            end
         end
         if (sat_clr) cnt_m = 0;
         else if (popped && e.sat && cnt_m < CNT_MAX) cnt_m++;
         hold_v = out_valid && !out_ready;
         hold_e.key    = int'(out_key);
         hold_e.mirror = out_mirror;
         hold_e.sat    = out_sat;
         if (in_valid && in_ready) q.push_back(model(int'($signed(in_data))));
      end
   end

   task automatic push(input int d);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'(d);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("push_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input int key, input bit mirror, input bit sat);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check({name, "_lat"}, lat, 2);
      check({name, "_key"}, int'(out_key), key);
      check({name, "_mirror"}, int'(out_mirror), int'(mirror));
      check({name, "_sat"}, int'(out_sat), int'(sat));
   endtask

   initial begin
      vec_t vecs[14];
      int   idx;
      int   n;
      int   budget;
      int   tmp;
      bit   acc;
      int   got[3];

      vecs[0]  = '{256,    -16,  1'b1, 1'b0};
      vecs[1]  = '{8192,   -512, 1'b1, 1'b0};
      vecs[2]  = '{8208,   -512, 1'b1, 1'b1};
      vecs[3]  = '{-32768, -512, 1'b0, 1'b1};
      vecs[4]  = '{0,      0,    1'b0, 1'b0};
      vecs[5]  = '{-256,   -16,  1'b0, 1'b0};
      vecs[6]  = '{32767,  -512, 1'b1, 1'b1};
      vecs[7]  = '{1,      -1,   1'b1, 1'b0};
      vecs[8]  = '{-1,     -1,   1'b0, 1'b0};
      vecs[9]  = '{16,     -1,   1'b1, 1'b0};
      vecs[10] = '{17,     -2,   1'b1, 1'b0};
      vecs[11] = '{-8192,  -512, 1'b0, 1'b0};
      vecs[12] = '{-8193,  -512, 1'b0, 1'b1};
      vecs[13] = '{-15,    -1,   1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_key", int'(out_key), 0);
      check("rst_out_mirror", int'(out_mirror), 0);
      check("rst_out_sat", int'(out_sat), 0);
      check("rst_sat_cnt", int'(sat_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         push(vecs[i].data);
         expect_out($sformatf("vec%0d", i), vecs[i].key, vecs[i].mirror, vecs[i].sat);
         if (i == 3) begin
            @(negedge clk);
            check("sat_cnt_boundary", int'(sat_cnt), 2);
         end
      end

      // Back-to-back -256 then 0.
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'(-256);
      @(posedge clk); #1;
      in_data = 16'(0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_first_valid", int'(out_valid), 1);
      check("b2b_first_key", int'(out_key), -16);
      check("b2b_first_mirror", int'(out_mirror), 0);
      @(negedge clk);
      check("b2b_second_valid", int'(out_valid), 1);
      check("b2b_second_key", int'(out_key), 0);
      check("b2b_second_mirror", int'(out_mirror), 0);

      // Backpressure: 6 stalled cycles while offering 16, 32, 48.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'(16); idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            in_data = 16'(16 * (idx + 1));
         end
      end
      @(negedge clk);
      check("bp_accepted", idx, 2);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_head_key", int'(out_key), -1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0; budget = 0;
      while (n < 3 && budget < 20) begin
         @(negedge clk);
         budget++;
         if (out_valid) begin
            got[n] = int'(out_key);
            n++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) in_valid = 1'b0;
      end
      check("bp_count", n, 3);
      check("bp_key0", got[0], -1);
      check("bp_key1", got[1], -2);
      check("bp_key2", got[2], -3);
      in_valid = 1'b0;

      // Counter: clear, clear-beats-increment, then saturation at the top.
      repeat (3) @(posedge clk);
      #1 sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      @(negedge clk);
      check("sat_clr_zero", int'(sat_cnt), 0);
      push(-32768);
      @(posedge clk); #1;
      sat_clr = 1'b1;
      @(negedge clk);
      check("clr_coinc_valid", int'(out_valid), 1);
      check("clr_coinc_sat", int'(out_sat), 1);
      @(posedge clk); #1;
      sat_clr = 1'b0;
      @(negedge clk);
      check("clr_coinc_cnt", int'(sat_cnt), 0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'h8000;
      repeat (20) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sat_cnt_max_hold", int'(sat_cnt), CNT_MAX);

      // Reset with both stages full.
      @(posedge clk); #1;
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      push(-32768);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_rst_cnt", int'(sat_cnt), 1);
      out_ready = 1'b0;
      push(100);
      push(200);
      @(negedge clk);
      check("full_out_valid", int'(out_valid), 1);
      check("full_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_sat_cnt", int'(sat_cnt), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;
      push(256);
      expect_out("post_rst", -16, 1'b1, 1'b0);

      // Randomised traffic against the scoreboard.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: in_data = 16'($urandom);
            1: begin tmp = int'($urandom_range(8150, 8250)); in_data = 16'(tmp); end
            2: begin tmp = int'($urandom_range(8150, 8250)); in_data = 16'(-tmp); end
            default: begin tmp = int'($urandom_range(0, 64)) - 32; in_data = 16'(tmp); end
         endcase
         out_ready = ($urandom_range(0, 2) != 0);
         sat_clr   = ($urandom_range(0, 30) == 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("drain_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
